// File: rtl/ddr_pkg.sv
// Shared types and pin encodings for the DDR4 command issuer.
// Command pin codes are ordered {cs_n, act_n, RAS_n, CAS_n, WE_n}.
package ddr_pkg;

    typedef enum logic [2:0] {
        CMD_WR  = 3'd0,
        CMD_RD  = 3'd1,
        CMD_PRE = 3'd2,
        CMD_REF = 3'd3,
        CMD_MRS = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE_R = 2'd0,
        WR_R   = 2'd1,
        RD_R   = 2'd2
    } req_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACT    = 3'd1,
        ST_TRCD_W = 3'd2,
        ST_CAS    = 3'd3,
        ST_LAT_W  = 3'd4,
        ST_WBURST = 3'd5,
        ST_HOLD   = 3'd6
    } state_e;

    // ACT carries row bit 14 on WE_n, so its LSB is replaced at issue time.
    localparam logic [4:0] PIN_ACT = 5'b00110;
    localparam logic [4:0] PIN_WR  = 5'b01100;
    localparam logic [4:0] PIN_RD  = 5'b01101;
    localparam logic [4:0] PIN_PRE = 5'b01010;
    localparam logic [4:0] PIN_REF = 5'b01001;
    localparam logic [4:0] PIN_MRS = 5'b01000;
    localparam logic [4:0] PIN_DES = 5'b11111;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [14:0] row;
        logic [9:0]  col;
        logic        bc4;
        logic        pre_all;
        logic [63:0] wr_data;
    } req_t;

    function automatic logic [5:0] lat_load(input int unsigned p);
        return 6'(p - 32'd1);
    endfunction

endpackage

// File: rtl/ddr_cmd_issuer_chk.sv
// Simulation-only parameter range checks for the command issuer.
module ddr_cmd_issuer_chk #(
    parameter int unsigned TRCD = 4,
    parameter int unsigned CWL  = 9,
    parameter int unsigned CL   = 11,
    parameter int unsigned TRP  = 4,
    parameter int unsigned TRFC = 16,
    parameter int unsigned TMRD = 8
) (
    input logic clk,
    input logic rst_n
);

    // Timing counters are 6 bits wide and need at least one wait cycle.
    a_param_range: assert property (@(posedge clk) disable iff (!rst_n)
        (TRCD >= 2) && (CWL >= 2) && (CL >= 2) && (TRP >= 2) && (TRFC >= 2) && (TMRD >= 2) &&
        (TRCD <= 64) && (CWL <= 64) && (CL <= 64) && (TRP <= 64) && (TRFC <= 64) && (TMRD <= 64))
        else $error("ddr_cmd_issuer timing parameter out of range");

endmodule

// File: rtl/ddr_wr_serializer.sv
// Write-burst serializer: one idle-data preamble cycle with dq_oe high, then
// 8 (BL8) or 4 (BC4) byte beats; dqs is center-aligned from the falling edge.
module ddr_wr_serializer
    import ddr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        bc4,
    input  logic [63:0] data,
    output logic [7:0]  dq,
    output logic        dq_oe,
    output logic        dqs_t,
    output logic        dqs_c
);

    logic [63:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pre_q, pre_d;
    logic        oe_q, oe_d;
    logic [7:0]  dq_q, dq_d;
    logic        dqs_t_q, dqs_t_d;
    logic        dqs_c_q, dqs_c_d;

    // Beat sequencing: cnt holds the beats remaining including the current one.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        oe_d    = oe_q;
        dq_d    = dq_q;
        if (start) begin
            shift_d = data;
            cnt_d   = bc4 ? 4'd4 : 4'd8;
            pre_d   = 1'b1;
            oe_d    = 1'b1;
            dq_d    = 8'd0;
        end else if (pre_q) begin
            pre_d   = 1'b0;
            dq_d    = shift_q[7:0];
            shift_d = {8'd0, shift_q[63:8]};
        end else if (oe_q) begin
            if (cnt_q == 4'd1) begin
                oe_d  = 1'b0;
                dq_d  = 8'd0;
                cnt_d = 4'd0;
            end else begin
                dq_d    = shift_q[7:0];
                shift_d = {8'd0, shift_q[63:8]};
                cnt_d   = cnt_q - 4'd1;
            end
        end else begin
            oe_d = 1'b0;
        end
    end

    // Even beats leave an even count remaining, so dqs_t is high mid even beats.
    always_comb begin
        dqs_t_d = oe_q & ~pre_q & ~cnt_q[0];
        dqs_c_d = ~dqs_t_d;
    end

    // Data path registers, launched on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 64'd0;
            cnt_q   <= 4'd0;
            pre_q   <= 1'b0;
            oe_q    <= 1'b0;
            dq_q    <= 8'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            oe_q    <= oe_d;
            dq_q    <= dq_d;
        end
    end

    // Strobe registers, launched on the falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dqs_t_q <= 1'b0;
            dqs_c_q <= 1'b1;
        end else begin
            dqs_t_q <= dqs_t_d;
            dqs_c_q <= dqs_c_d;
        end
    end

    assign dq    = dq_q;
    assign dq_oe = oe_q;
    assign dqs_t = dqs_t_q;
    assign dqs_c = dqs_c_q;

endmodule

// File: rtl/ddr_cmd_issuer.sv
// DDR4 command/address issuer: sequences one scheduler request at a time onto
// the command pins and drives write bursts through ddr_wr_serializer.
module ddr_cmd_issuer
    import ddr_pkg::*;
#(
    parameter int unsigned TRCD = 4,
    parameter int unsigned CWL  = 9,
    parameter int unsigned CL   = 11,
    parameter int unsigned TRP  = 4,
    parameter int unsigned TRFC = 16,
    parameter int unsigned TMRD = 8
) (
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [1:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [14:0] req_row,
    input  logic [9:0]  req_col,
    input  logic        req_bc4,
    input  logic        req_pre_all,
    input  logic [63:0] req_wr_data,
    output logic        cs_n,
    output logic        act_n,
    output logic        RAS_n_A16,
    output logic        CAS_n_A15,
    output logic        WE_n_A14,
    output logic [1:0]  bg_addr,
    output logic [1:0]  ba_addr,
    output logic        A13,
    output logic        A12_BC_n,
    output logic        A11,
    output logic        A10_AP,
    output logic [9:0]  A9_A0,
    output logic [7:0]  dq,
    output logic        dq_oe,
    output logic        dqs_t,
    output logic        dqs_c,
    output logic [1:0]  dimm_req,
    output logic        rd_rdy
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic [4:0]  pins_q, pins_d;
    logic [1:0]  bg_q, bg_d, ba_q, ba_d;
    logic [13:0] addr_q, addr_d;
    logic        ready_q, ready_d;
    logic        rd_rdy_q, rd_rdy_d;
    req_e        dimm_q, dimm_d;
    logic        ser_start_s;

    // Next-state, wait counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = ST_ACT;
                    req_d   = '{cmd: req_cmd, bg: req_bg, ba: req_ba, row: req_row, col: req_col,
                                bc4: req_bc4, pre_all: req_pre_all, wr_data: req_wr_data};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACT: begin
                case (req_q.cmd)
                    CMD_WR, CMD_RD: begin state_d = ST_TRCD_W; cnt_d = lat_load(TRCD); end
                    CMD_PRE:        begin state_d = ST_HOLD;   cnt_d = lat_load(TRP);  end
                    CMD_REF:        begin state_d = ST_HOLD;   cnt_d = lat_load(TRFC); end
                    CMD_MRS:        begin state_d = ST_HOLD;   cnt_d = lat_load(TMRD); end
                    default:        state_d = ST_IDLE;
                endcase
            end
            ST_TRCD_W: begin
                if (cnt_q == 6'd1) begin
                    state_d = ST_CAS;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_CAS: begin
                state_d = ST_LAT_W;
                cnt_d   = (req_q.cmd == CMD_WR) ? lat_load(CWL) : lat_load(CL);
            end
            ST_LAT_W: begin
                if (cnt_q != 6'd1) begin
                    cnt_d = cnt_q - 6'd1;
                end else if (req_q.cmd == CMD_WR) begin
                    state_d = ST_WBURST;
                    cnt_d   = req_q.bc4 ? 6'd4 : 6'd8;
                end else begin
                    // One HOLD cycle carries the rd_rdy pulse.
                    state_d = ST_HOLD;
                    cnt_d   = 6'd1;
                end
            end
            ST_WBURST, ST_HOLD: begin
                if (cnt_q == 6'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin leaves a flop.
    always_comb begin
        pins_d      = PIN_DES;
        bg_d        = 2'd0;
        ba_d        = 2'd0;
        addr_d      = 14'd0;
        ready_d     = (state_d == ST_IDLE);
        rd_rdy_d    = (state_d == ST_HOLD) && (req_d.cmd == CMD_RD);
        dimm_d      = IDLE_R;
        ser_start_s = (state_d == ST_LAT_W) && (cnt_d == 6'd1) && (req_d.cmd == CMD_WR);
        case (state_d)
            ST_ACT: begin
                case (req_d.cmd)
                    CMD_WR, CMD_RD: begin
                        pins_d = {PIN_ACT[4:1], req_d.row[14]};
                        addr_d = req_d.row[13:0];
                        bg_d   = req_d.bg;
                        ba_d   = req_d.ba;
                    end
                    CMD_PRE: begin
                        pins_d     = PIN_PRE;
                        addr_d[10] = req_d.pre_all;
                        bg_d       = req_d.bg;
                        ba_d       = req_d.ba;
                    end
                    CMD_REF: pins_d = PIN_REF;
                    CMD_MRS: begin
                        pins_d = PIN_MRS;
                        addr_d = req_d.row[13:0];
                        bg_d   = req_d.bg;
                        ba_d   = req_d.ba;
                    end
                    default: pins_d = PIN_DES;
                endcase
            end
            ST_CAS: begin
                pins_d       = (req_d.cmd == CMD_WR) ? PIN_WR : PIN_RD;
                addr_d[9:0]  = req_d.col;
                addr_d[12]   = ~req_d.bc4;
                bg_d         = req_d.bg;
                ba_d         = req_d.ba;
            end
            default: pins_d = PIN_DES;
        endcase
        if (state_d != ST_IDLE) begin
            case (req_d.cmd)
                CMD_WR:  dimm_d = WR_R;
                CMD_RD:  dimm_d = RD_R;
                default: dimm_d = IDLE_R;
            endcase
        end else begin
            dimm_d = IDLE_R;
        end
    end

    // State and output registers.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            req_q    <= '0;
            pins_q   <= PIN_DES;
            bg_q     <= 2'd0;
            ba_q     <= 2'd0;
            addr_q   <= 14'd0;
            ready_q  <= 1'b1;
            rd_rdy_q <= 1'b0;
            dimm_q   <= IDLE_R;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            pins_q   <= pins_d;
            bg_q     <= bg_d;
            ba_q     <= ba_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
            rd_rdy_q <= rd_rdy_d;
            dimm_q   <= dimm_d;
        end
    end

    ddr_wr_serializer u_ser (
        .clk   (CK_t),
        .rst_n (reset_n),
        .start (ser_start_s),
        .bc4   (req_q.bc4),
        .data  (req_q.wr_data),
        .dq    (dq),
        .dq_oe (dq_oe),
        .dqs_t (dqs_t),
        .dqs_c (dqs_c)
    );

    ddr_cmd_issuer_chk #(
        .TRCD(TRCD), .CWL(CWL), .CL(CL), .TRP(TRP), .TRFC(TRFC), .TMRD(TMRD)
    ) u_chk (
        .clk   (CK_t),
        .rst_n (reset_n)
    );

    assign {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = pins_q;
    assign {A13, A12_BC_n, A11, A10_AP, A9_A0}           = addr_q;
    assign bg_addr   = bg_q;
    assign ba_addr   = ba_q;
    assign req_ready = ready_q;
    assign rd_rdy    = rd_rdy_q;
    assign dimm_req  = dimm_q;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Self-checking bench for ddr_cmd_issuer: vector table plus per-cycle
// expected-output scoreboard, with back-to-back and mid-burst reset sequences.
module tb_ddr_cmd_issuer;
    import ddr_pkg::*;

    localparam int TRCD = 4;
    localparam int CWL  = 9;
    localparam int CL   = 11;

    logic        CK_t = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_cmd;
    logic [1:0]  req_bg, req_ba;
    logic [14:0] req_row;
    logic [9:0]  req_col;
    logic        req_bc4, req_pre_all;
    logic [63:0] req_wr_data;
    logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic [1:0]  bg_addr, ba_addr;
    logic        A13, A12_BC_n, A11, A10_AP;
    logic [9:0]  A9_A0;
    logic [7:0]  dq;
    logic        dq_oe, dqs_t, dqs_c;
    logic [1:0]  dimm_req;
    logic        rd_rdy;

    ddr_cmd_issuer dut (
        .CK_t(CK_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .req_col(req_col), .req_bc4(req_bc4), .req_pre_all(req_pre_all),
        .req_wr_data(req_wr_data), .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16),
        .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14), .bg_addr(bg_addr), .ba_addr(ba_addr),
        .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
        .dq(dq), .dq_oe(dq_oe), .dqs_t(dqs_t), .dqs_c(dqs_c), .dimm_req(dimm_req),
        .rd_rdy(rd_rdy)
    );

    always #5 CK_t = ~CK_t;

    typedef struct packed {
        logic [4:0]  pins;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [13:0] addr;
        logic        oe;
        logic [7:0]  dq;
        logic        rd;
        logic [1:0]  dimm;
        logic        ready;
    } obs_t;

    typedef struct {
        string       nm;
        int          cyc;
        obs_t        e;
        logic [13:0] amask;
        bit          bchk;
        bit          dchk;
    } sb_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [14:0] row;
        logic [9:0]  col;
        logic        bc4;
        logic        pre_all;
        logic [63:0] data;
        int          rdy_cyc;
        int          rises;
        string       nm;
    } vec_t;

    vec_t vt[9];
    sb_t  sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   t_rises = 0;
    int   c_rises = 0;

    always @(posedge dqs_t) t_rises++;
    always @(posedge dqs_c) c_rises++;

    function automatic obs_t sample();
        obs_t a;
        a.pins  = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14};
        a.bg    = bg_addr;
        a.ba    = ba_addr;
        a.addr  = {A13, A12_BC_n, A11, A10_AP, A9_A0};
        a.oe    = dq_oe;
        a.dq    = dq;
        a.rd    = rd_rdy;
        a.dimm  = dimm_req;
        a.ready = req_ready;
        return a;
    endfunction

    // Expected per-cycle outputs of one request, cycle 0 = accept cycle.
    task automatic push_trace(input vec_t v, input int last);
        int  d0;
        int  beats;
        bit  is_wr;
        bit  is_rd;
        sb_t s;
        d0    = 1 + TRCD + CWL;
        beats = v.bc4 ? 4 : 8;
        is_wr = (v.cmd == CMD_WR);
        is_rd = (v.cmd == CMD_RD);
        for (int c = 0; c <= last; c++) begin
            s.nm = v.nm; s.cyc = c; s.e = '0; s.amask = '0; s.bchk = 1'b0; s.dchk = 1'b0;
            s.e.pins  = 5'b11111;
            s.e.ready = (c == 0) || (c == v.rdy_cyc);
            if ((is_wr || is_rd) && c >= 1 && c < v.rdy_cyc)
                s.e.dimm = is_wr ? WR_R : RD_R;
            if (c == 1) begin
                case (v.cmd)
                    CMD_WR, CMD_RD: begin
                        s.e.pins = {4'b0011, v.row[14]}; s.e.addr = v.row[13:0];
                        s.amask = 14'h3FFF; s.bchk = 1'b1; s.e.bg = v.bg; s.e.ba = v.ba;
                    end
                    CMD_PRE: begin
                        s.e.pins = 5'b01010; s.e.addr[10] = v.pre_all;
                        s.amask = 14'h0400; s.bchk = 1'b1; s.e.bg = v.bg; s.e.ba = v.ba;
                    end
                    CMD_REF: s.e.pins = 5'b01001;
                    CMD_MRS: begin
                        s.e.pins = 5'b01000; s.e.addr = v.row[13:0];
                        s.amask = 14'h3FFF; s.bchk = 1'b1; s.e.bg = v.bg; s.e.ba = v.ba;
                    end
                    default: s.e.pins = 5'b11111;
                endcase
            end
            if ((is_wr || is_rd) && c == 1 + TRCD) begin
                s.e.pins = is_wr ? 5'b01100 : 5'b01101;
                s.e.addr = {1'b0, ~v.bc4, 1'b0, 1'b0, v.col};
                s.amask  = 14'b01011111111111;
                s.bchk = 1'b1; s.e.bg = v.bg; s.e.ba = v.ba;
            end
            if (is_wr && c >= d0 - 1 && c < d0 + beats) s.e.oe = 1'b1;
            if (is_wr && c >= d0 && c < d0 + beats) begin
                s.e.dq = v.data[8*(c-d0) +: 8];
                s.dchk = 1'b1;
            end
            if (is_rd && c == 1 + TRCD + CL) s.e.rd = 1'b1;
            sb_q.push_back(s);
        end
    endtask

    // One clock: compare on the falling edge, return just after the rising edge.
    task automatic step();
        sb_t  s;
        obs_t a;
        @(negedge CK_t);
        if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            a = sample();
            a.addr = (a.addr & s.amask) | (s.e.addr & ~s.amask);
            if (!s.bchk) begin a.bg = s.e.bg; a.ba = s.e.ba; end
            if (!s.dchk) a.dq = s.e.dq;
            vectors++;
            if (a !== s.e) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got pins=%b bg=%0d ba=%0d addr=%h oe=%b dq=%h rd=%b req=%0d rdy=%b, exp pins=%b bg=%0d ba=%0d addr=%h oe=%b dq=%h rd=%b req=%0d rdy=%b",
                         s.nm, s.cyc, a.pins, a.bg, a.ba, a.addr, a.oe, a.dq, a.rd, a.dimm, a.ready,
                         s.e.pins, s.e.bg, s.e.ba, s.e.addr, s.e.oe, s.e.dq, s.e.rd, s.e.dimm, s.e.ready);
            end
        end
        @(posedge CK_t);
        #1;
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 200) begin
            step();
            guard++;
        end
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard not drained, %0d left, required 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic drive(input vec_t v);
        req_cmd = v.cmd; req_bg = v.bg; req_ba = v.ba; req_row = v.row;
        req_col = v.col; req_bc4 = v.bc4; req_pre_all = v.pre_all; req_wr_data = v.data;
    endtask

    task automatic scramble();
        req_cmd = 3'($urandom_range(0, 4)); req_bg = 2'($urandom); req_ba = 2'($urandom);
        req_row = 15'($urandom); req_col = 10'($urandom); req_bc4 = 1'($urandom);
        req_pre_all = 1'($urandom); req_wr_data = {$urandom, $urandom};
    endtask

    task automatic check_dqs(input string nm, input int t0, input int c0, input int exp_r);
        vectors++;
        if (t_rises - t0 != exp_r || c_rises - c0 != exp_r || dqs_t !== 1'b0 || dqs_c !== 1'b1) begin
            miscompares++;
            $display("FAIL %s dqs: got t_rises=%0d c_rises=%0d rest=%b%b, exp %0d %0d rest=01",
                     nm, t_rises - t0, c_rises - c0, dqs_t, dqs_c, exp_r, exp_r);
        end
    endtask

    task automatic check_reset(input string nm);
        obs_t e;
        e = '0; e.pins = 5'b11111; e.ready = 1'b1;
        vectors++;
        if ({sample(), dqs_t, dqs_c} !== {e, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL %s: got %b, exp %b", nm, {sample(), dqs_t, dqs_c}, {e, 1'b0, 1'b1});
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t0, c0;
        t0 = t_rises; c0 = c_rises;
        drive(v);
        req_valid = 1'b1;
        push_trace(v, v.rdy_cyc);
        step();
        req_valid = 1'b0;
        scramble();
        drain(v.nm);
        check_dqs(v.nm, t0, c0, v.rises);
    endtask

    initial begin
        int t0, c0;
        vt[0] = '{CMD_WR,  2'd1, 2'd2, 15'h1234, 10'h3F8, 1'b0, 1'b0, 64'h8877665544332211, 22, 4, "wr_bl8"};
        vt[1] = '{CMD_WR,  2'd0, 2'd3, 15'h4321, 10'h008, 1'b1, 1'b0, 64'hFFEEDDCC44332211, 18, 2, "wr_bc4"};
        vt[2] = '{CMD_RD,  2'd3, 2'd1, 15'h7ABC, 10'h155, 1'b0, 1'b0, 64'd0, 17, 0, "rd"};
        vt[3] = '{CMD_PRE, 2'd2, 2'd0, 15'h0000, 10'h000, 1'b0, 1'b1, 64'd0, 5, 0, "pre_all"};
        vt[4] = '{CMD_PRE, 2'd1, 2'd3, 15'h7FFF, 10'h3FF, 1'b0, 1'b0, 64'd0, 5, 0, "pre_one"};
        vt[5] = '{CMD_REF, 2'd0, 2'd0, 15'h0000, 10'h000, 1'b0, 1'b0, 64'd0, 17, 0, "ref"};
        vt[6] = '{CMD_MRS, 2'd1, 2'd1, 15'h0A5C, 10'h000, 1'b0, 1'b0, 64'd0, 9, 0, "mrs"};
        vt[7] = '{CMD_WR,  2'd3, 2'd3, 15'h7FFF, 10'h3FF, 1'b0, 1'b0, 64'h0123456789ABCDEF, 22, 4, "wr_bl8_b"};
        vt[8] = '{CMD_RD,  2'd0, 2'd0, 15'h0000, 10'h000, 1'b1, 1'b0, 64'd0, 17, 0, "rd_bc4"};

        reset_n = 1'b0; req_valid = 1'b0;
        scramble();
        repeat (3) @(posedge CK_t);
        #1;
        check_reset("reset");
        reset_n = 1'b1;
        @(posedge CK_t);
        #1;

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        // Second request held valid during a write is taken only once idle.
        t0 = t_rises; c0 = c_rises;
        drive(vt[0]);
        req_valid = 1'b1;
        push_trace(vt[0], vt[0].rdy_cyc - 1);
        push_trace(vt[2], vt[2].rdy_cyc);
        step();
        drive(vt[2]);
        for (int i = 0; i < 22; i++) step();
        req_valid = 1'b0;
        drain("b2b");
        check_dqs("b2b", t0, c0, 4);

        // Reset during beat 3 of a BL8 write.
        drive(vt[0]);
        req_valid = 1'b1;
        push_trace(vt[0], 16);
        step();
        req_valid = 1'b0;
        drain("rst_pre");
        vectors++;
        if (dq_oe !== 1'b1 || dq !== 8'h44) begin
            miscompares++;
            $display("FAIL rst_beat3: got oe=%b dq=%h, exp oe=1 dq=44", dq_oe, dq);
        end
        #1 reset_n = 1'b0;
        #1 check_reset("rst_mid");
        repeat (2) @(posedge CK_t);
        #2 check_reset("rst_hold");
        @(negedge CK_t);
        reset_n = 1'b1;
        @(posedge CK_t);
        #1;
        run_vec(vt[3]);
        run_vec(vt[1]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_issuer.md
Name: ddr_cmd_issuer

Overview:
- Controller-side transmitter for the DDR4 command/address and write-data interface; the initiator that drives the DIMM model's pins.
- Accepts one transaction at a time from the scheduler (ACT+WR, ACT+RD, PRE, REF, MRS) and sequences it onto cs_n/act_n/RAS/CAS/WE/address pins with JEDEC-style spacing.
- For writes, serializes a 64-bit payload into BL8 or BC4 beats on dq with toggling dqs_t/dqs_c.
- For reads, raises rd_rdy at CAS latency.

Parameters:
- TRCD, 4, ACT-to-CAS spacing in CK_t cycles (≥2)
- CWL, 9, WR command to first data beat, cycles (≥2)
- CL, 11, RD command to rd_rdy pulse, cycles (≥2)
- TRP, 4, PRE occupancy, cycles
- TRFC, 16, REF occupancy, cycles
- TMRD, 8, MRS occupancy, cycles

Ports:
- CK_t in 1: sole clock
- reset_n in 1: asynchronous, active-low reset
- req_valid in 1: request present
- req_ready out 1: issuer idle, accepts request
- req_cmd in 3: cmd_e (CMD_WR, CMD_RD, CMD_PRE, CMD_REF, CMD_MRS)
- req_bg in 2: bank group
- req_ba in 2: bank address
- req_row in 15: row address / MRS opcode
- req_col in 10: column address
- req_bc4 in 1: 1 = burst chop 4, 0 = BL8
- req_pre_all in 1: PRE drives A10_AP=1
- req_wr_data in 64: write payload; beat k = bits [8k+7:8k]
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14 out 1 each: command pins
- bg_addr out 2, ba_addr out 2: bank pins
- A13, A12_BC_n, A11, A10_AP out 1 each: address pins
- A9_A0 out 10: address pins
- dq out 8: write data
- dq_oe out 1: dq drive enable
- dqs_t, dqs_c out 1 each: write strobe pair
- dimm_req out 2: req_e (IDLE_R, WR_R, RD_R) of the transaction in flight
- rd_rdy out 1: one-cycle pulse at CL after RD

Behaviour:
- Reset (async, reset_n=0):
  - command pins all 1 (DES); address, bank and dq outputs 0; dq_oe=0; dqs_t=0, dqs_c=1
  - dimm_req=IDLE_R; rd_rdy=0; req_ready=1; state IDLE
  - Reset mid-transaction aborts immediately and returns these values; no partial burst resumes.
- Encodings {cs_n,act_n,RAS,CAS,WE}:
  - ACT: cs_n=0, act_n=0; row on {WE_n_A14,A13,A12_BC_n,A11,A10_AP,A9_A0}; RAS=CAS=1
  - WR 01100; RD 01101; PRE 01010; REF 01001; MRS 01000; DES 11111
- CAS command: col on A9_A0; A12_BC_n = ~req_bc4; A10_AP=0.
- Every command occupies exactly one cycle; all non-command cycles drive DES.
- Handshake: accept on req_valid & req_ready (cycle 0). req_ready drops the next cycle and stays low until the state returns to IDLE. Inputs are registered at accept; later changes are ignored.
- FSM states: IDLE, ACT, TRCD_W, CAS, LAT_W, WBURST, HOLD.
  - WR/RD: IDLE → ACT at cycle 1 → TRCD_W for TRCD-1 cycles → CAS at cycle 1+TRCD → LAT_W.
  - WR: LAT_W lasts CWL-1 cycles → WBURST for 8 (BL8) or 4 (BC4) beats → IDLE.
  - RD: LAT_W lasts CL-1 cycles; rd_rdy=1 for the single cycle 1+TRCD+CL; → IDLE the next cycle.
  - PRE/REF/MRS: command at cycle 1 → HOLD for TRP-1 / TRFC-1 / TMRD-1 cycles → IDLE.
  - MRS: req_bg/req_ba select the register; req_row is the opcode.
- Write data:
  - dq_oe rises one cycle before beat 0 and falls after the last beat.
  - dq beat k is launched on posedge CK_t.
  - dqs toggles on negedge CK_t (center-aligned): dqs_t=1 mid even beats, 0 mid odd beats; dqs_c = ~dqs_t.
  - After the last beat, dqs returns to 0/1. BL8 gives 4 dqs_t rising edges and 4 dqs_c rising edges; BC4 gives 2 each.
- dimm_req: WR_R or RD_R from the ACT cycle through the cycle before IDLE; IDLE_R otherwise, including during PRE/REF/MRS.
- Latency counter is 6 bits and loads (param-1). Parameters below 2 are out of scope and flagged by a simulation assertion.
- req_valid while busy: no effect, no queuing.

Decomposition:
- Add to ddr_pkg: cmd_e; command pin constants (ACT/WR/RD/PRE/REF/MRS/DES 5-bit codes); req_e if not already present.
- Sub-module ddr_wr_serializer: 64→8-bit beat shifter with dqs/dq_oe generation, started by the FSM with the bc4 flag.

Test Plan:
- Reset: hold reset_n=0 mid-write at beat 3 → pins 11111, dq_oe=0, dqs_t=0/dqs_c=1, req_ready=1 while low.
- WR BL8 (defaults), bg=1, ba=2, row=0x1234, col=0x3F8, data=0x8877665544332211:
  - ACT at cycle 1 with A9_A0=0x234, A13..A10=0100 (row bits), WE=0
  - WR 01100 at cycle 5 with A9_A0=0x3F8, A12_BC_n=1
  - dq=0x11..0x88 on cycles 14–21; dq_oe cycles 13–21; req_ready high at cycle 22
- WR BC4 with data 0x...44332211 → 4 beats 0x11–0x44 on cycles 14–17; A12_BC_n=0 on CAS; 2 dqs_t rising edges.
- RD → RD 01101 at cycle 5; rd_rdy high only at cycle 16; dimm_req=RD_R cycles 1–16; dq_oe never asserted.
- PRE with pre_all=1 → 01010 and A10_AP=1 at cycle 1; req_ready back at cycle 5. REF → ready at cycle 17.
- Back-to-back: req_valid held high with a second RD during a WR → second accepted only on cycle 22; no DES gap violated; no command overlap.
